led_matrix: RTL and testbench
=============================

Name: led_matrix

Overview:
- Row-multiplexed scan driver for an 8x8 LED matrix.
- Takes a 64-bit frame, `matdata`, as 8 row bytes and steps through rows 0..7 continuously while `en` is high.
- Each step first presents that row's column pattern with row drive blanked (`shiftcol` strobe), then asserts that row's one-hot select (`shiftrow` strobe) for a dwell period.
- Sits between the frame source and the external row/column driver latches.

Parameters:
- BLANK_CYCLES, 1: cycles with all rows off after each new column pattern is loaded; legal range >= 1.
- DWELL_CYCLES, 16: cycles each row is driven on; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- nrst  input  1  reset, synchronous, active-low.
- en  input  1  scan enable; high = scanning, low = blank and pause.
- matdata  input  8x8 (64)  packed frame; `matdata[r]` is the column byte for row r, so row 0 = bits 7:0 and row 7 = bits 63:56; bit c = LED (r,c) on.
- rowdata  output  8  one-hot row select, active-high; 0 = all rows off.
- coldata  output  8  column pattern of the current row, active-high.
- shiftrow  output  1  one-cycle strobe: `rowdata` just updated to a new select.
- shiftcol  output  1  one-cycle strobe: `coldata` just updated.

Behaviour:
- Reset (`nrst`=0 at a clock edge) has priority over everything:
  - state=IDLE, row=0, cnt=0.
  - `rowdata`=0, `coldata`=0, `shiftrow`=0, `shiftcol`=0.
- All outputs are registered.
- Internal state:
  - 3-bit row index.
  - Cycle counter wide enough for max(BLANK_CYCLES, DWELL_CYCLES).
  - State machine with states IDLE, BLANK, SHOW.
- IDLE, `en`=1 at an edge:
  - state<=BLANK, `coldata`<=`matdata[row]`, `rowdata`<=0, `shiftcol`<=1, cnt<=0.
- BLANK:
  - `shiftcol`<=0.
  - When cnt==BLANK_CYCLES-1: state<=SHOW, `rowdata`<=1<<row, `shiftrow`<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- SHOW:
  - `shiftrow`<=0.
  - When cnt==DWELL_CYCLES-1: row<=row+1 (7 wraps to 0), state<=BLANK, `rowdata`<=0, `coldata`<=`matdata[row+1 mod 8]`, `shiftcol`<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- Timing:
  - Row period = BLANK_CYCLES+DWELL_CYCLES cycles; frame period = 8x that.
  - Latency from the first edge with `en`=1 to `shiftcol` high = 1 cycle.
- `en`=0 at any edge in BLANK or SHOW:
  - state<=IDLE, `rowdata`<=0, `shiftrow`<=0, `shiftcol`<=0, cnt<=0.
  - `coldata` and row index hold.
  - On re-enable, the scan restarts the same row from BLANK.
- `matdata` sampling:
  - Sampled only on edges that assert `shiftcol`.
  - Changes at other times take effect at the next row load; no tearing within a row.
- Invariants:
  - `rowdata` is always 0 or one-hot.
  - `rowdata` is never nonzero on the same cycle `shiftcol` is 1.
  - `shiftrow` and `shiftcol` are never high together.
  - Each strobe is exactly one cycle wide.
- `en` held high continuously gives a free-running scan with no gaps beyond the blank phases.

Test Plan:
- Reset: `nrst`=0 for 2 edges with `en`=1 and `matdata`=64'h0011223344556677 -> all outputs 0, no strobes.
- Full scan, defaults (BLANK=1, DWELL=16), same `matdata`, release reset:
  - Next edge: `coldata`=8'h77, `shiftcol`=1, `rowdata`=0.
  - Following edge: `rowdata`=8'h01, `shiftrow`=1.
  - `rowdata`=8'h01 held 16 cycles.
  - Then `coldata`=8'h66 with `rowdata`=0, then `rowdata`=8'h02.
  - Continues through row 7 with `coldata`=8'h00 and `rowdata`=8'h80.
  - Wraps to row 0 with `coldata`=8'h77, 136 cycles after the first `shiftcol`.
- Strobe checks over 3 frames:
  - Exactly 24 `shiftcol` and 24 `shiftrow` pulses, each 1 cycle wide, never coincident.
  - `rowdata` always 0 or one-hot.
- Enable pause:
  - Drop `en` mid-SHOW of row 3 -> next edge `rowdata`=0 and `coldata` holds 8'h44.
  - Raise `en` -> `shiftcol` with `coldata`=8'h44, then `rowdata`=8'h08.
- Data update: change `matdata` to all-FF mid-row 2 -> row 2 `coldata` stays 8'h55; row 3 loads 8'hFF.
- Reset mid-scan: assert `nrst`=0 during SHOW of row 5 -> next edge all outputs 0; after release the scan restarts at row 0.

Source files
------------

// File: rtl/led_matrix.sv
// Row-multiplexed scan driver for an 8x8 LED matrix.
// Each row is shown in two phases: its column pattern is loaded with all
// rows off (BLANK), then the row's one-hot select is driven (SHOW).
// Rows advance 0..7 and wrap while en is high.
module led_matrix #(
    parameter int BLANK_CYCLES = 1,
    parameter int DWELL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [63:0] matdata,
    output logic [7:0]  rowdata,
    output logic [7:0]  coldata,
    output logic        shiftrow,
    output logic        shiftcol
);

    localparam int MAX_CYCLES = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [2:0]       row, row_n, row_inc;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       rowdata_n, coldata_n;
    logic             shiftrow_n, shiftcol_n;

    // Column byte for row r of the packed frame (row 0 in bits 7:0).
    function automatic logic [7:0] col_of(input logic [63:0] frame, input logic [2:0] r);
        return frame[{r, 3'b000} +: 8];
    endfunction

    // One-hot row select for row r.
    function automatic logic [7:0] row_sel(input logic [2:0] r);
        return 8'b1 << r;
    endfunction

    assign row_inc = row + 3'd1;

    // Next-state and next-output decode; strobes default low so each is one cycle wide.
    always_comb begin
        state_n    = state;
        row_n      = row;
        cnt_n      = cnt;
        rowdata_n  = rowdata;
        coldata_n  = coldata;
        shiftrow_n = 1'b0;
        shiftcol_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (en) begin
                    state_n    = BLANK;
                    coldata_n  = col_of(matdata, row);
                    rowdata_n  = 8'h00;
                    shiftcol_n = 1'b1;
                    cnt_n      = '0;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_n   = IDLE;
                    rowdata_n = 8'h00;
                    cnt_n     = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_n    = SHOW;
                    rowdata_n  = row_sel(row);
                    shiftrow_n = 1'b1;
                    cnt_n      = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_n   = IDLE;
                    rowdata_n = 8'h00;
                    cnt_n     = '0;
                end else if (cnt == DWELL_LAST) begin
                    // Row drive goes off in the same cycle the next pattern lands.
                    state_n    = BLANK;
                    row_n      = row_inc;
                    rowdata_n  = 8'h00;
                    coldata_n  = col_of(matdata, row_inc);
                    shiftcol_n = 1'b1;
                    cnt_n      = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                rowdata_n = 8'h00;
                cnt_n     = '0;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            row      <= 3'd0;
            cnt      <= '0;
            rowdata  <= 8'h00;
            coldata  <= 8'h00;
            shiftrow <= 1'b0;
            shiftcol <= 1'b0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            cnt      <= cnt_n;
            rowdata  <= rowdata_n;
            coldata  <= coldata_n;
            shiftrow <= shiftrow_n;
            shiftcol <= shiftcol_n;
        end
    end

endmodule

// File: tb/tb_led_matrix.sv
// Scoreboard bench for led_matrix: the stimulus process queues the expected
// strobe sequence; the monitor pops and checks each strobe as it appears.
module tb_led_matrix;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [63:0] matdata;
    logic [7:0]  rowdata;
    logic [7:0]  coldata;
    logic        shiftrow;
    logic        shiftcol;

    localparam logic [63:0] FRAME = 64'h0011223344556677;
    localparam int DWELL = 16;
    localparam int BLANK = 1;

    led_matrix dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .matdata  (matdata),
        .rowdata  (rowdata),
        .coldata  (coldata),
        .shiftrow (shiftrow),
        .shiftcol (shiftcol)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_col;
        logic [7:0] col;
        logic [7:0] row;
        int         gap;
    } ev_t;

    ev_t q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_strobe = 0;
    int n_col = 0;
    int n_row = 0;
    bit prev_col = 1'b0;
    bit prev_row = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] f, input int r);
        return f[r*8 +: 8];
    endfunction

    // Queue the two strobes of one row: pattern load, then row select.
    task automatic push_row(input logic [7:0] col, input int r, input int col_gap);
        ev_t e;
        e.is_col = 1'b1; e.col = col; e.row = 8'h00; e.gap = col_gap;
        q.push_back(e);
        e.is_col = 1'b0; e.col = col; e.row = 8'(1 << r); e.gap = BLANK;
        q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, checks strobes against the queue and invariants.
    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (shiftcol === 1'b1 || shiftrow === 1'b1) begin
            chk("strobes_exclusive", {31'd0, shiftcol & shiftrow}, 32'd0);
            if (shiftcol === 1'b1) begin
                n_col++;
                chk("shiftcol_width", {31'd0, prev_col}, 32'd0);
            end
            if (shiftrow === 1'b1) begin
                n_row++;
                chk("shiftrow_width", {31'd0, prev_row}, 32'd0);
            end
            if (q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, shiftcol, shiftrow}, 32'd0);
            end else begin
                e = q.pop_front();
                chk(e.is_col ? "strobe_kind_col" : "strobe_kind_row",
                    {31'd0, shiftcol}, {31'd0, e.is_col});
                chk("coldata", {24'd0, coldata}, {24'd0, e.col});
                chk("rowdata", {24'd0, rowdata}, {24'd0, e.row});
                if (e.gap >= 0)
                    chk("strobe_spacing", cyc - last_strobe, e.gap);
            end
            last_strobe = cyc;
        end
        if (nrst === 1'b1 && cyc > 2) begin
            chk("rowdata_onehot0", {31'd0, $onehot0(rowdata)}, 32'd1);
            if (shiftcol === 1'b1)
                chk("rowdata_off_on_shiftcol", {24'd0, rowdata}, 32'd0);
        end
        prev_col = (shiftcol === 1'b1);
        prev_row = (shiftrow === 1'b1);
    end

    // Wait for the row-select strobe of a given row, bounded.
    task automatic wait_row(input logic [7:0] r);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(shiftrow === 1'b1 && rowdata === r) && n < 2000);
        if (n >= 2000) chk("wait_row_timeout", {24'd0, rowdata}, {24'd0, r});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rowdata"}, {24'd0, rowdata}, 32'd0);
        chk({tag, "_coldata"}, {24'd0, coldata}, 32'd0);
        chk({tag, "_shiftrow"}, {31'd0, shiftrow}, 32'd0);
        chk({tag, "_shiftcol"}, {31'd0, shiftcol}, 32'd0);
    endtask

    initial begin
        int n;
        nrst    = 1'b0;
        en      = 1'b1;
        matdata = FRAME;

        // Reset held for two edges with en high: nothing may come out.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("reset");

        // Three full frames plus rows 0..3 of the fourth.
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < 8; r++)
                push_row(byte_of(FRAME, r), r, (f == 0 && r == 0) ? -1 : DWELL);
        for (int r = 0; r < 4; r++)
            push_row(byte_of(FRAME, r), r, DWELL);
        nrst = 1'b1;

        // Strobe totals over three frames.
        n = 0;
        while (n_row < 24 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("frames3_shiftcol_count", n_col, 24);
        chk("frames3_shiftrow_count", n_row, 24);

        // Pause in the middle of row 3.
        wait_row(8'h08);
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk); #1;
        chk("pause_rowdata", {24'd0, rowdata}, 32'd0);
        chk("pause_coldata_hold", {24'd0, coldata}, 32'h44);
        chk("pause_shiftcol", {31'd0, shiftcol}, 32'd0);
        repeat (3) @(negedge clk);
        chk("pause_coldata_still", {24'd0, coldata}, 32'h44);

        // Resume re-shows row 3; frame source switches to all-FF during row 2.
        push_row(8'h44, 3, -1);
        for (int r = 4; r < 8; r++) push_row(byte_of(FRAME, r), r, DWELL);
        for (int r = 0; r < 3; r++) push_row(byte_of(FRAME, r), r, DWELL);
        for (int r = 3; r < 6; r++) push_row(8'hFF, r, DWELL);
        en = 1'b1;
        wait_row(8'h08);
        wait_row(8'h04);
        repeat (5) @(negedge clk);
        matdata = {64{1'b1}};

        // Reset in the middle of row 5.
        wait_row(8'h20);
        repeat (4) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk); #1;
        check_all_zero("midreset");
        chk("midreset_queue_drained", q.size(), 0);
        @(negedge clk);
        matdata = FRAME;
        push_row(8'h77, 0, -1);
        push_row(8'h66, 1, DWELL);
        nrst = 1'b1;
        wait_row(8'h02);
        en = 1'b0;
        repeat (3) @(negedge clk); #1;
        chk("final_queue_drained", q.size(), 0);
        chk("final_rowdata_off", {24'd0, rowdata}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
